atm_txn_arbiter: RTL and testbench

Serializes account transactions (balance query, withdraw, deposit, transfer) from NUM_PORTS ATM terminal front-ends onto one shared single-port balance memory. Round-robin arbitration between terminals. Read-check-write sequencing enforces funds, overflow and index checks. Sits between the terminal FSMs and the balance store, so no two terminals ever modify balances concurrently.

---
 rtl/atm_pkg.sv | 34 +++
 rtl/atm_txn_arbiter_if.sv | 33 +++
 rtl/rr_arbiter.sv | 27 ++
 rtl/atm_txn_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_atm_txn_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/atm_pkg.sv
// Shared types for the ATM transaction arbiter: op codes, response status
// codes, sequencer state encoding and default widths.
package atm_pkg;

    localparam int NUM_PORTS_DEF    = 2;
    localparam int NUM_ACCOUNTS_DEF = 10;
    localparam int IDX_W_DEF        = 4;
    localparam int BAL_W_DEF        = 8;

    typedef enum logic [1:0] {
        OP_BALANCE  = 2'b00,
        OP_WITHDRAW = 2'b01,
        OP_DEPOSIT  = 2'b10,
        OP_TRANSFER = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        STAT_OK           = 2'b00,
        STAT_ERR_FUNDS    = 2'b01,
        STAT_ERR_INDEX    = 2'b10,
        STAT_ERR_OVERFLOW = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_SRC,
        S_RD_DST,
        S_EXEC,
        S_WR_SRC,
        S_WR_DST,
        S_RESP
    } state_e;

endpackage

// File: rtl/atm_txn_arbiter_if.sv
// Terminal request/response bus plus the balance-memory port of the arbiter.
interface atm_txn_arbiter_if #(
    parameter int NUM_PORTS = atm_pkg::NUM_PORTS_DEF,
    parameter int IDX_W     = atm_pkg::IDX_W_DEF,
    parameter int BAL_W     = atm_pkg::BAL_W_DEF
);
    logic [NUM_PORTS-1:0]       ReqValid;
    logic [NUM_PORTS-1:0]       ReqReady;
    logic [2*NUM_PORTS-1:0]     ReqOp;
    logic [IDX_W*NUM_PORTS-1:0] ReqSrc;
    logic [IDX_W*NUM_PORTS-1:0] ReqDst;
    logic [BAL_W*NUM_PORTS-1:0] ReqAmount;
    logic [NUM_PORTS-1:0]       RespValid;
    logic [1:0]                 RespStatus;
    logic [BAL_W-1:0]           RespBalance;
    logic [IDX_W-1:0]           MemAddr;
    logic                       MemWe;
    logic [BAL_W-1:0]           MemWdata;
    logic [BAL_W-1:0]           MemRdata;
    logic                       Busy;

    modport slave (
        input  ReqValid, ReqOp, ReqSrc, ReqDst, ReqAmount, MemRdata,
        output ReqReady, RespValid, RespStatus, RespBalance,
               MemAddr, MemWe, MemWdata, Busy
    );

    modport master (
        output ReqValid, ReqOp, ReqSrc, ReqDst, ReqAmount, MemRdata,
        input  ReqReady, RespValid, RespStatus, RespBalance,
               MemAddr, MemWe, MemWdata, Busy
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first requester at or
// after ptr, wrapping around.
module rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int PTR_W     = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant
);
    // Distance of each port from the pointer in circular order; smaller wins.
    logic [PTR_W-1:0] pos [NUM_PORTS];

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_pos
        assign pos[gi] = PTR_W'((gi + NUM_PORTS - int'(ptr)) % NUM_PORTS);
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            grant[i] = req[i];
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (req[j] && (pos[j] < pos[i])) grant[i] = 1'b0;
            end
        end
    end
endmodule

// File: rtl/atm_txn_arbiter.sv
// Serialises terminal transactions onto one single-port balance memory using a
// read-check-write sequence, with round-robin arbitration between terminals.
module atm_txn_arbiter
    import atm_pkg::*;
#(
    parameter int NUM_PORTS    = NUM_PORTS_DEF,
    parameter int NUM_ACCOUNTS = NUM_ACCOUNTS_DEF,
    parameter int IDX_W        = IDX_W_DEF,
    parameter int BAL_W        = BAL_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    atm_txn_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [1:0]       op_port  [NUM_PORTS];
    logic [IDX_W-1:0] src_port [NUM_PORTS];
    logic [IDX_W-1:0] dst_port [NUM_PORTS];
    logic [BAL_W-1:0] amt_port [NUM_PORTS];

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
        assign op_port[gi]  = bus.ReqOp[2*gi +: 2];
        assign src_port[gi] = bus.ReqSrc[IDX_W*gi +: IDX_W];
        assign dst_port[gi] = bus.ReqDst[IDX_W*gi +: IDX_W];
        assign amt_port[gi] = bus.ReqAmount[BAL_W*gi +: BAL_W];
    end

    state_e               state_reg;
    op_e                  op_reg;
    status_e              status_reg;
    logic [PTR_W-1:0]     rr_ptr_reg, gnt_reg;
    logic [IDX_W-1:0]     src_reg, dst_reg, mem_addr_reg;
    logic [BAL_W-1:0]     amount_reg, src_bal_reg, dst_new_reg, mem_wdata_reg, resp_bal_reg;
    logic                 mem_we_reg;
    logic [NUM_PORTS-1:0] resp_valid_reg;

    logic [NUM_PORTS-1:0] grant, gnt_onehot;
    logic [PTR_W-1:0]     grant_idx, rr_ptr_next;
    logic                 accept;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PTR_W(PTR_W)) u_rr (
        .req   (bus.ReqValid),
        .ptr   (rr_ptr_reg),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) grant_idx = PTR_W'(i);
        end
    end

    // Gated by Reset so ReqReady is already low while reset is asserted.
    assign bus.ReqReady = (state_reg == S_IDLE && Reset) ? grant : '0;
    assign accept       = (state_reg == S_IDLE) && (|grant);
    assign gnt_onehot   = NUM_PORTS'(1) << gnt_reg;
    assign rr_ptr_next  = (int'(gnt_reg) == NUM_PORTS - 1) ? '0 : gnt_reg + 1'b1;

    function automatic logic index_bad(input op_e op, input logic [IDX_W-1:0] s,
                                       input logic [IDX_W-1:0] d);
        return (int'(s) >= NUM_ACCOUNTS) || (op == OP_TRANSFER && int'(d) >= NUM_ACCOUNTS);
    endfunction

    // Funds/overflow evaluation; only meaningful while in EXEC.
    logic [BAL_W-1:0] exec_src_bal, new_src_next, dst_new_next;
    logic [BAL_W:0]   sum_src, sum_dst;
    status_e          status_next;
    logic             write_next;

    always_comb begin
        exec_src_bal = (op_reg == OP_TRANSFER) ? src_bal_reg : bus.MemRdata;
        sum_src      = {1'b0, exec_src_bal} + {1'b0, amount_reg};
        sum_dst      = {1'b0, bus.MemRdata} + {1'b0, amount_reg};
        status_next  = STAT_OK;
        new_src_next = exec_src_bal;
        dst_new_next = sum_dst[BAL_W-1:0];
        write_next   = 1'b0;
        case (op_reg)
            OP_BALANCE: ;
            OP_WITHDRAW: begin
                if (amount_reg > exec_src_bal) status_next = STAT_ERR_FUNDS;
                else begin
                    new_src_next = exec_src_bal - amount_reg;
                    write_next   = 1'b1;
                end
            end
            OP_DEPOSIT: begin
                if (sum_src[BAL_W]) status_next = STAT_ERR_OVERFLOW;
                else begin
                    new_src_next = sum_src[BAL_W-1:0];
                    write_next   = 1'b1;
                end
            end
            OP_TRANSFER: begin
                if (src_reg == dst_reg) ;
                else if (amount_reg > exec_src_bal) status_next = STAT_ERR_FUNDS;
                else if (sum_dst[BAL_W]) status_next = STAT_ERR_OVERFLOW;
                else begin
                    new_src_next = exec_src_bal - amount_reg;
                    write_next   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg      <= S_IDLE;
            op_reg         <= OP_BALANCE;
            status_reg     <= STAT_OK;
            rr_ptr_reg     <= '0;
            gnt_reg        <= '0;
            src_reg        <= '0;
            dst_reg        <= '0;
            amount_reg     <= '0;
            src_bal_reg    <= '0;
            dst_new_reg    <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_we_reg     <= 1'b0;
            resp_bal_reg   <= '0;
            resp_valid_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: if (accept) begin
                    gnt_reg      <= grant_idx;
                    op_reg       <= op_e'(op_port[grant_idx]);
                    src_reg      <= src_port[grant_idx];
                    dst_reg      <= dst_port[grant_idx];
                    amount_reg   <= amt_port[grant_idx];
                    // Out-of-range requests never put their index on the memory bus.
                    mem_addr_reg <= index_bad(op_e'(op_port[grant_idx]), src_port[grant_idx],
                                              dst_port[grant_idx]) ? '0 : src_port[grant_idx];
                    state_reg    <= S_RD_SRC;
                end
                S_RD_SRC: begin
                    if (index_bad(op_reg, src_reg, dst_reg)) begin
                        status_reg     <= STAT_ERR_INDEX;
                        resp_bal_reg   <= '0;
                        resp_valid_reg <= gnt_onehot;
                        state_reg      <= S_RESP;
                    end else if (op_reg == OP_TRANSFER) begin
                        mem_addr_reg <= dst_reg;
                        state_reg    <= S_RD_DST;
                    end else begin
                        state_reg <= S_EXEC;
                    end
                end
                S_RD_DST: begin
                    src_bal_reg <= bus.MemRdata;
                    state_reg   <= S_EXEC;
                end
                S_EXEC: begin
                    status_reg   <= status_next;
                    resp_bal_reg <= new_src_next;
                    dst_new_reg  <= dst_new_next;
                    if (write_next) begin
                        mem_we_reg    <= 1'b1;
                        mem_addr_reg  <= src_reg;
                        mem_wdata_reg <= new_src_next;
                        state_reg     <= S_WR_SRC;
                    end else begin
                        resp_valid_reg <= gnt_onehot;
                        state_reg      <= S_RESP;
                    end
                end
                S_WR_SRC: begin
                    if (op_reg == OP_TRANSFER) begin
                        mem_addr_reg  <= dst_reg;
                        mem_wdata_reg <= dst_new_reg;
                        state_reg     <= S_WR_DST;
                    end else begin
                        mem_we_reg     <= 1'b0;
                        resp_valid_reg <= gnt_onehot;
                        state_reg      <= S_RESP;
                    end
                end
                S_WR_DST: begin
                    mem_we_reg     <= 1'b0;
                    resp_valid_reg <= gnt_onehot;
                    state_reg      <= S_RESP;
                end
                S_RESP: begin
                    resp_valid_reg <= '0;
                    rr_ptr_reg     <= rr_ptr_next;
                    state_reg      <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.RespValid   = resp_valid_reg;
    assign bus.RespStatus  = status_reg;
    assign bus.RespBalance = resp_bal_reg;
    assign bus.MemAddr     = mem_addr_reg;
    assign bus.MemWe       = mem_we_reg;
    assign bus.MemWdata    = mem_wdata_reg;
    assign bus.Busy        = (state_reg != S_IDLE);
endmodule

// File: tb/tb_atm_txn_arbiter.sv
// Bench for atm_txn_arbiter: registered-read balance memory, account-ledger
// reference model, directed plan followed by randomized transactions.
module tb_atm_txn_arbiter;
    localparam int NP = 2;
    localparam int NA = 10;
    localparam int IW = 4;
    localparam int BW = 8;
    localparam int MAXBAL = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_load = 1'b1;
    always #5 clk = ~clk;

    atm_txn_arbiter_if #(.NUM_PORTS(NP), .IDX_W(IW), .BAL_W(BW)) bus ();

    atm_txn_arbiter #(.NUM_PORTS(NP), .NUM_ACCOUNTS(NA), .IDX_W(IW), .BAL_W(BW)) dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    function automatic int preload(input int a);
        case (a)
            3:       return 100;
            5:       return 250;
            7:       return 20;
            default: return 0;
        endcase
    endfunction

    // Single-port memory with one-cycle registered read.
    logic [BW-1:0] mem [16];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= BW'(preload(i));
        end else if (bus.MemWe) begin
            mem[bus.MemAddr] <= bus.MemWdata;
        end
        bus.MemRdata <= mem[bus.MemAddr];
    end

    int ref_bal [16];
    int ref_ptr;
    int checks = 0;
    int errors = 0;
    int p_op [NP], p_src [NP], p_dst [NP], p_amt [NP];
    int exp_wa [$], exp_wd [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input int op, input int s, input int d, input int a);
        p_op[p] = op; p_src[p] = s; p_dst[p] = d; p_amt[p] = a;
    endtask

    task automatic drive_fields();
        for (int p = 0; p < NP; p++) begin
            bus.ReqOp[2*p +: 2]      = 2'(p_op[p]);
            bus.ReqSrc[IW*p +: IW]    = IW'(p_src[p]);
            bus.ReqDst[IW*p +: IW]    = IW'(p_dst[p]);
            bus.ReqAmount[BW*p +: BW] = BW'(p_amt[p]);
        end
    endtask

    // Ledger semantics: index check, then funds, then overflow; latency is
    // one read cycle per account read, one check cycle, one per write, one response.
    function automatic void model(input int op, input int s, input int d, input int a,
                                  output int st, output int bal, output int lat);
        exp_wa.delete();
        exp_wd.delete();
        if (s >= NA || (op == 3 && d >= NA)) begin
            st = 2; bal = 0; lat = 2;
            return;
        end
        st  = 0;
        lat = (op == 3) ? 4 : 3;
        case (op)
            1: if (a > ref_bal[s]) st = 1;
               else begin ref_bal[s] -= a; exp_wa.push_back(s); exp_wd.push_back(ref_bal[s]); end
            2: if (ref_bal[s] + a > MAXBAL) st = 3;
               else begin ref_bal[s] += a; exp_wa.push_back(s); exp_wd.push_back(ref_bal[s]); end
            3: if (s != d) begin
                   if (a > ref_bal[s]) st = 1;
                   else if (ref_bal[d] + a > MAXBAL) st = 3;
                   else begin
                       ref_bal[s] -= a; ref_bal[d] += a;
                       exp_wa.push_back(s); exp_wd.push_back(ref_bal[s]);
                       exp_wa.push_back(d); exp_wd.push_back(ref_bal[d]);
                   end
               end
            default: ;
        endcase
        lat += exp_wa.size();
        bal  = ref_bal[s];
    endfunction

    task automatic wait_ready();
        int waited;
        waited = 0;
        #1;
        while (bus.ReqReady == '0 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
    endtask

    // Called on a falling edge; returns on the falling edge of the response cycle.
    task automatic run_txn(input logic [NP-1:0] mask);
        int g, cyc, st, bal, lat;
        int ow_a [$], ow_d [$], ow_c [$];
        g = 0;
        for (int k = NP - 1; k >= 0; k--) if (mask[(ref_ptr + k) % NP]) g = (ref_ptr + k) % NP;
        drive_fields();
        bus.ReqValid = mask;
        wait_ready();
        check("grant", bus.ReqReady, NP'(1) << g);
        model(p_op[g], p_src[g], p_dst[g], p_amt[g], st, bal, lat);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus.ReqValid[g] = 1'b0;
                check("busy", bus.Busy, 1);
            end
            if (bus.MemWe) begin
                ow_a.push_back(int'(bus.MemAddr));
                ow_d.push_back(int'(bus.MemWdata));
                ow_c.push_back(cyc);
            end
        end while (bus.RespValid == '0 && cyc < 20);
        check("latency", cyc, lat);
        check("resp_port", bus.RespValid, NP'(1) << g);
        check("status", bus.RespStatus, st);
        check("balance", bus.RespBalance, bal);
        check("num_writes", ow_a.size(), exp_wa.size());
        for (int i = 0; i < exp_wa.size() && i < ow_a.size(); i++) begin
            check("wr_addr", ow_a[i], exp_wa[i]);
            check("wr_data", ow_d[i], exp_wd[i]);
            if (i > 0) check("wr_back_to_back", ow_c[i] - ow_c[i-1], 1);
        end
        $display("txn port=%0d op=%0d src=%0d dst=%0d amt=%0d -> status=%0d bal=%0d lat=%0d writes=%0d",
                 g, p_op[g], p_src[g], p_dst[g], p_amt[g], bus.RespStatus, bus.RespBalance,
                 cyc, ow_a.size());
        ref_ptr = (g + 1) % NP;
    endtask

    initial begin
        int waited;
        for (int i = 0; i < 16; i++) ref_bal[i] = preload(i);
        ref_ptr = 0;
        set_port(0, 0, 3, 0, 0);
        set_port(1, 0, 5, 0, 0);
        drive_fields();
        bus.ReqValid = 2'b11;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.ReqReady, 0);
        check("rst_busy", bus.Busy, 0);
        check("rst_memwe", bus.MemWe, 0);
        check("rst_respvalid", bus.RespValid, 0);
        check("rst_memaddr", bus.MemAddr, 0);
        bus.ReqValid = '0;
        mem_load = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Directed plan.
        set_port(0, 0, 3, 0, 0);   run_txn(2'b01);
        set_port(1, 1, 3, 0, 30);  run_txn(2'b10);
        set_port(1, 1, 3, 0, 80);  run_txn(2'b10);
        set_port(0, 2, 5, 0, 10);  run_txn(2'b01);
        set_port(0, 2, 5, 0, 5);   run_txn(2'b01);
        set_port(1, 2, 3, 0, 30);  run_txn(2'b10);
        set_port(0, 3, 3, 7, 50);  run_txn(2'b01);
        set_port(0, 0, 3, 0, 0);
        set_port(1, 0, 5, 0, 0);
        repeat (4) run_txn(2'b11);
        set_port(1, 1, 12, 0, 1);  run_txn(2'b10);
        set_port(0, 3, 3, 11, 1);  run_txn(2'b01);
        set_port(1, 3, 7, 7, 200); run_txn(2'b10);

        // Reset while the debit write of a transfer is on the bus.
        set_port(0, 3, 3, 7, 10);
        set_port(1, 0, 5, 0, 0);
        drive_fields();
        bus.ReqValid = 2'b01;
        wait_ready();
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
            if (waited == 1) bus.ReqValid = '0;
        end while (!bus.MemWe && waited < 20);
        check("reached_wr_src", bus.MemWe, 1);
        bus.ReqValid = 2'b11;
        rst_n = 1'b0;
        #1;
        check("midrst_memwe", bus.MemWe, 0);
        check("midrst_busy", bus.Busy, 0);
        check("midrst_ready", bus.ReqReady, 0);
        repeat (2) begin
            @(negedge clk);
            check("midrst_respvalid", bus.RespValid, 0);
        end
        rst_n = 1'b1;
        ref_ptr = 0;
        set_port(0, 0, 3, 0, 0);
        set_port(1, 0, 7, 0, 0);
        run_txn(2'b11);
        run_txn(2'b11);

        // Randomized traffic against the ledger model.
        for (int n = 0; n < 40; n++) begin
            for (int p = 0; p < NP; p++) begin
                set_port(p, int'($urandom_range(0, 3)), int'($urandom_range(0, 11)),
                         int'($urandom_range(0, 11)),
                         ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                     : int'($urandom_range(0, 60)));
            end
            run_txn(NP'($urandom_range(1, 3)));
        end

        bus.ReqValid = '0;
        repeat (2) @(negedge clk);
        check("final_busy", bus.Busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
